// File: rtl/regbank_pkg.sv
// Shared types and sizes for the register-bank sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regbank_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  typedef enum logic [1:0] {
    OP_LOADI = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_AND   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_EXEC  = 2'b10,
    S_WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/regbank_alu.sv
// Combinational ALU: LOADI passes operand a, ADD/SUB/AND on a,b, with carry/borrow and zero flags.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs.
module regbank_alu
  import regbank_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_result,
  output logic         o_c,
  output logic         o_z
);

  logic [W:0] w_wide;

  // Opcode decode; the extra top bit of the wide sum/difference is carry or borrow.
  always_comb begin
    w_wide   = '0;
    o_result = '0;
    o_c      = 1'b0;
    case (op_e'(i_op))
      OP_LOADI: o_result = i_a;
      OP_ADD: begin
        w_wide   = {1'b0, i_a} + {1'b0, i_b};
        o_result = w_wide[W-1:0];
        o_c      = w_wide[W];
      end
      OP_SUB: begin
        // Borrow out of the (W+1)-bit difference is set exactly when a < b unsigned.
        w_wide   = {1'b0, i_a} - {1'b0, i_b};
        o_result = w_wide[W-1:0];
        o_c      = w_wide[W];
      end
      OP_AND:  o_result = i_a & i_b;
      default: o_result = '0;
    endcase
  end

  assign o_z = (o_result == '0);

endmodule

// File: rtl/regbank_sequencer.sv
// Sequencer: accept a command, read two bank registers, run the ALU, write the result back.
// Latency: accept edge N -> write strobe in cycle N+3 -> next accept at edge N+4 (1 cmd / 4 cycles).
// Backpressure: cmd_ready is high only in IDLE; cmd_valid is ignored while a command is in flight.
module regbank_sequencer
  import regbank_pkg::*;
#(
  parameter int DATA_W = regbank_pkg::DATA_W,
  parameter int ADDR_W = regbank_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs0,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] add_rd0,
  output logic [ADDR_W-1:0] add_rd1,
  input  logic [DATA_W-1:0] rd0,
  input  logic [DATA_W-1:0] rd1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] add_wr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_c,
  output logic              flag_z
);

  state_e            r_state;
  state_e            w_next_state;
  logic              w_accept;

  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_add_rd0;
  logic [ADDR_W-1:0] r_add_rd1;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_op0;
  logic [DATA_W-1:0] r_op1;

  logic [DATA_W-1:0] r_result;
  logic              r_flag_c;
  logic              r_flag_z;
  logic              r_wr_en;
  logic              r_done;

  logic [DATA_W-1:0] w_alu_a;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_c;
  logic              w_alu_z;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  assign cmd_ready = (r_state == S_IDLE);

  // LOADI reuses the ALU pass-through path by presenting the immediate on operand a.
  assign w_alu_a = (r_op == OP_LOADI) ? r_imm : r_op0;

  regbank_alu #(.W(DATA_W)) u_alu (
    .i_op     (r_op),
    .i_a      (w_alu_a),
    .i_b      (r_op1),
    .o_result (w_alu_result),
    .o_c      (w_alu_c),
    .o_z      (w_alu_z)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic: fixed four-step walk, leaving IDLE only on a handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_READ;
      S_READ:  w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_WRITE;
      S_WRITE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Command latch; the source addresses go straight to the bank address pins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= '0;
      r_add_rd0 <= '0;
      r_add_rd1 <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
    end else if (w_accept) begin
      r_op      <= cmd_op;
      r_add_rd0 <= cmd_rs0;
      r_add_rd1 <= cmd_rs1;
      r_rd      <= cmd_rd;
      r_imm     <= cmd_imm;
    end
  end

  // Operand capture at the end of READ, while the bank is presenting the source data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op0 <= '0;
      r_op1 <= '0;
    end else if (r_state == S_READ) begin
      r_op0 <= rd0;
      r_op1 <= rd1;
    end
  end

  // Result and flags update only at the end of EXEC and hold until the next command.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_result <= w_alu_result;
      r_flag_c <= w_alu_c;
      r_flag_z <= w_alu_z;
    end
  end

  // Write strobe straight from flops so it cannot glitch; low for exactly the WRITE cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_en <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_wr_en <= (r_state != S_EXEC);
      r_done  <= (r_state == S_EXEC);
    end
  end

  assign add_rd0 = r_add_rd0;
  assign add_rd1 = r_add_rd1;
  assign wr_en   = r_wr_en;
  assign add_wr  = r_rd;
  assign wr_data = r_result;
  assign done    = r_done;
  assign result  = r_result;
  assign flag_c  = r_flag_c;
  assign flag_z  = r_flag_z;

endmodule

// File: tb/tb_regbank_sequencer.sv
// Directed bench for regbank_sequencer with a 4x8 register bank model attached.
// Latency: checks write strobe exactly three cycles after each accept.
// Backpressure: checks cmd_ready spacing with cmd_valid held high.
module tb_regbank_sequencer;
  import regbank_pkg::*;

  logic       clock;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_rs0;
  logic [1:0] cmd_rs1;
  logic [1:0] cmd_rd;
  logic [7:0] cmd_imm;
  logic [1:0] add_rd0;
  logic [1:0] add_rd1;
  logic [7:0] rd0;
  logic [7:0] rd1;
  logic       wr_en;
  logic [1:0] add_wr;
  logic [7:0] wr_data;
  logic       done;
  logic [7:0] result;
  logic       flag_c;
  logic       flag_z;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] bank [4];

  regbank_sequencer #(.DATA_W(8), .ADDR_W(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rs0   (cmd_rs0),
    .cmd_rs1   (cmd_rs1),
    .cmd_rd    (cmd_rd),
    .cmd_imm   (cmd_imm),
    .add_rd0   (add_rd0),
    .add_rd1   (add_rd1),
    .rd0       (rd0),
    .rd1       (rd1),
    .wr_en     (wr_en),
    .add_wr    (add_wr),
    .wr_data   (wr_data),
    .done      (done),
    .result    (result),
    .flag_c    (flag_c),
    .flag_z    (flag_z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register bank: active-high reset tied to ~reset_n, write on active-low wr_en, combinational reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) bank[i] <= 8'h00;
    end else if (!wr_en) begin
      bank[add_wr] <= wr_data;
    end
  end
  assign rd0 = bank[add_rd0];
  assign rd1 = bank[add_rd1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full command with cycle-by-cycle checks; starts and ends on a falling edge in IDLE.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] rs0, input logic [1:0] rs1,
                         input logic [1:0] rd, input logic [7:0] imm,
                         input logic [7:0] exp_data, input logic exp_c, input logic exp_z);
    @(negedge clock);
    chk("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rs0   = rs0;
    cmd_rs1   = rs1;
    cmd_rd    = rd;
    cmd_imm   = imm;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(negedge clock);  // READ
    chk("read_addr0", add_rd0, rs0);
    chk("read_addr1", add_rd1, rs1);
    chk("read_wren", wr_en, 1);
    chk("read_ready", cmd_ready, 0);
    @(negedge clock);  // EXEC
    chk("exec_wren", wr_en, 1);
    chk("exec_done", done, 0);
    @(negedge clock);  // WRITE
    chk("wr_wren", wr_en, 0);
    chk("wr_done", done, 1);
    chk("wr_addr", add_wr, rd);
    chk("wr_data", wr_data, exp_data);
    chk("wr_flag_c", flag_c, exp_c);
    chk("wr_flag_z", flag_z, exp_z);
    @(negedge clock);  // back in IDLE
    chk("post_wren", wr_en, 1);
    chk("post_done", done, 0);
    chk("post_ready", cmd_ready, 1);
    chk("post_result_hold", result, exp_data);
    chk("post_bank", bank[rd], exp_data);
  endtask

  logic [1:0] b2b_op   [3];
  logic [1:0] b2b_rd   [3];
  logic [7:0] b2b_imm  [3];
  logic [7:0] b2b_exp  [3];

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_rs0   = 2'b00;
    cmd_rs1   = 2'b00;
    cmd_rd    = 2'b00;
    cmd_imm   = 8'h00;

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_wren", wr_en, 1);
    chk("rst_add_rd0", add_rd0, 0);
    chk("rst_add_rd1", add_rd1, 0);
    chk("rst_add_wr", add_wr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flag_c", flag_c, 0);
    chk("rst_flag_z", flag_z, 0);
    reset_n = 1'b1;

    // LOADI r2 = 5A
    run_cmd(OP_LOADI, 2'd0, 2'd0, 2'd2, 8'h5A, 8'h5A, 1'b0, 1'b0);
    // F0 + 20 = 110 -> 10 with carry
    run_cmd(OP_LOADI, 2'd0, 2'd0, 2'd0, 8'hF0, 8'hF0, 1'b0, 1'b0);
    run_cmd(OP_LOADI, 2'd0, 2'd0, 2'd1, 8'h20, 8'h20, 1'b0, 1'b0);
    run_cmd(OP_ADD,   2'd0, 2'd1, 2'd3, 8'h00, 8'h10, 1'b1, 1'b0);
    // 20 - F0 wraps to 30 with borrow, written over r0
    run_cmd(OP_SUB,   2'd1, 2'd0, 2'd0, 8'h00, 8'h30, 1'b1, 1'b0);
    // r0 - r0 = 0: zero flag, no borrow
    run_cmd(OP_SUB,   2'd0, 2'd0, 2'd2, 8'h00, 8'h00, 1'b0, 1'b1);

    // cmd_valid held high across three commands; the ADD depends on both loads
    b2b_op[0] = OP_LOADI; b2b_rd[0] = 2'd0; b2b_imm[0] = 8'h07; b2b_exp[0] = 8'h07;
    b2b_op[1] = OP_LOADI; b2b_rd[1] = 2'd1; b2b_imm[1] = 8'h03; b2b_exp[1] = 8'h03;
    b2b_op[2] = OP_ADD;   b2b_rd[2] = 2'd2; b2b_imm[2] = 8'h00; b2b_exp[2] = 8'h0A;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = b2b_op[0];
    cmd_rs0   = 2'd0;
    cmd_rs1   = 2'd1;
    cmd_rd    = b2b_rd[0];
    cmd_imm   = b2b_imm[0];
    for (int i = 0; i < 3; i++) begin
      chk("b2b_ready_idle", cmd_ready, 1);
      @(posedge clock);
      #1;
      if (i < 2) begin
        cmd_op  = b2b_op[i+1];
        cmd_rd  = b2b_rd[i+1];
        cmd_imm = b2b_imm[i+1];
      end else begin
        cmd_valid = 1'b0;
      end
      for (int k = 1; k <= 3; k++) begin
        @(negedge clock);
        chk("b2b_ready_busy", cmd_ready, 0);
        if (k == 3) begin
          chk("b2b_wren", wr_en, 0);
          chk("b2b_wr_data", wr_data, b2b_exp[i]);
        end
      end
      @(negedge clock);
    end
    chk("b2b_ready_end", cmd_ready, 1);
    chk("b2b_bank_r2", bank[2], 8'h0A);

    // Reset pulled during EXEC of AND r1 = FF & 0F
    run_cmd(OP_LOADI, 2'd0, 2'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    run_cmd(OP_LOADI, 2'd0, 2'd0, 2'd3, 8'h0F, 8'h0F, 1'b0, 1'b0);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = OP_AND;
    cmd_rs0   = 2'd0;
    cmd_rs1   = 2'd3;
    cmd_rd    = 2'd1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(negedge clock);  // READ
    @(negedge clock);  // EXEC
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wren", wr_en, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_flag_c", flag_c, 0);
    chk("mid_rst_add_rd0", add_rd0, 0);
    chk("mid_rst_add_wr", add_wr, 0);
    @(posedge clock);
    #1 chk("mid_rst_wren_edge", wr_en, 1);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("post_rst_wren", wr_en, 1);
      chk("post_rst_ready", cmd_ready, 1);
    end
    chk("post_rst_bank_r1", bank[1], 8'h00);

    // Self-overwrite: r1 = r1 & r1
    run_cmd(OP_LOADI, 2'd0, 2'd0, 2'd1, 8'hA5, 8'hA5, 1'b0, 1'b0);
    run_cmd(OP_AND,   2'd1, 2'd1, 2'd1, 8'h00, 8'hA5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
